// File: rtl/dht11_responder.sv
// dht11_responder
// Emulates a DHT11 sensor on the single-wire DATA line. Qualifies the host
// start pulse, answers with the 80/80 us acknowledge, then shifts out
// RH_INT, RH_DEC, T_INT, T_DEC and a checksum using DHT11 pulse-width coding.
//
// Ports
//   CLK       in   system clock
//   RESET     in   asynchronous, active-high reset
//   DATA_IN   in   raw line level (asynchronous pad input)
//   DATA_OE   out  1 = pull line low, 0 = release
//   RH_INT    in   humidity integer byte
//   RH_DEC    in   humidity decimal byte
//   T_INT     in   temperature integer byte
//   T_DEC     in   temperature decimal byte
//   CSUM_ERR  in   invert the transmitted checksum when set at latch time
//   BUSY      out  high from start qualification until frame end
//   DONE      out  one-cycle pulse at frame completion
//   FRAMES    out  count of completed frames (wraps)
module dht11_responder #(
    parameter int CLK_FPGA     = 25000000,
    parameter int CYC_US       = CLK_FPGA / 1000000,
    parameter int START_MIN_US = 16000,
    parameter int TURN_US      = 30,
    parameter int ACK_US       = 80,
    parameter int BITLOW_US    = 50,
    parameter int ZERO_US      = 26,
    parameter int ONE_US       = 70
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        DATA_IN,
    output logic        DATA_OE,
    input  logic [7:0]  RH_INT,
    input  logic [7:0]  RH_DEC,
    input  logic [7:0]  T_INT,
    input  logic [7:0]  T_DEC,
    input  logic        CSUM_ERR,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] FRAMES
);

    // Phase lengths in cycles; "_LAST" is the final cnt value of a phase.
    localparam logic [31:0] START_CYC   = 32'(START_MIN_US * CYC_US);
    localparam logic [31:0] TURN_LAST   = 32'(TURN_US * CYC_US - 1);
    localparam logic [31:0] ACK_LAST    = 32'(ACK_US * CYC_US - 1);
    localparam logic [31:0] BITLOW_LAST = 32'(BITLOW_US * CYC_US - 1);
    localparam logic [31:0] ZERO_LAST   = 32'(ZERO_US * CYC_US - 1);
    localparam logic [31:0] ONE_LAST    = 32'(ONE_US * CYC_US - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_TURN,
        ST_ACK_LOW,
        ST_ACK_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        sync_meta_r;
    logic        ds_r;
    logic        ds_eff_s;
    logic [31:0] cnt_r;
    logic [39:0] shift_r;
    logic [5:0]  bit_idx_r;
    logic        latch_s;
    logic        bit_done_s;
    logic        frame_done_s;
    logic [31:0] hi_last_s;
    logic        data_oe_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] frames_r;

    // Mod-256 sum of the four data bytes, optionally inverted.
    function automatic logic [7:0] calc_csum(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d,
                                             input logic inv);
        logic [7:0] sum_v;
        sum_v = a + b + c + d;
        return inv ? ~sum_v : sum_v;
    endfunction

    // Two-flop synchronizer for the pad input; idles high like the pulled-up line.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_meta_r <= 1'b1;
            ds_r        <= 1'b1;
        end else begin
            sync_meta_r <= DATA_IN;
            ds_r        <= sync_meta_r;
        end
    end

    // Next-state logic and per-phase event strobes.
    always_comb begin
        state_s      = state_r;
        latch_s      = 1'b0;
        bit_done_s   = 1'b0;
        frame_done_s = 1'b0;
        // Our own pull-down must never look like host activity.
        ds_eff_s     = data_oe_r ? 1'b1 : ds_r;
        hi_last_s    = shift_r[39] ? ONE_LAST : ZERO_LAST;
        case (state_r)
            ST_IDLE: begin
                if (!ds_eff_s) begin
                    state_s = ST_HOST_LOW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOST_LOW: begin
                if (ds_eff_s) begin
                    if (cnt_r >= START_CYC) begin
                        state_s = ST_TURN;
                        latch_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOST_LOW;
                end
            end
            ST_TURN: begin
                if (cnt_r == TURN_LAST) begin
                    state_s = ST_ACK_LOW;
                end else begin
                    state_s = ST_TURN;
                end
            end
            ST_ACK_LOW: begin
                if (cnt_r == ACK_LAST) begin
                    state_s = ST_ACK_HIGH;
                end else begin
                    state_s = ST_ACK_LOW;
                end
            end
            ST_ACK_HIGH: begin
                if (cnt_r == ACK_LAST) begin
                    state_s = ST_BIT_LOW;
                end else begin
                    state_s = ST_ACK_HIGH;
                end
            end
            ST_BIT_LOW: begin
                if (cnt_r == BITLOW_LAST) begin
                    state_s = ST_BIT_HIGH;
                end else begin
                    state_s = ST_BIT_LOW;
                end
            end
            ST_BIT_HIGH: begin
                if (cnt_r == hi_last_s) begin
                    bit_done_s = 1'b1;
                    if (bit_idx_r == 6'd39) begin
                        state_s = ST_END_LOW;
                    end else begin
                        state_s = ST_BIT_LOW;
                    end
                end else begin
                    state_s = ST_BIT_HIGH;
                end
            end
            ST_END_LOW: begin
                if (cnt_r == BITLOW_LAST) begin
                    state_s      = ST_IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    state_s = ST_END_LOW;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and saturating phase counter, cleared on every state change.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 32'd0;
        end else begin
            state_r <= state_s;
            if ((state_s != state_r) || (state_r == ST_IDLE)) begin
                cnt_r <= 32'd0;
            end else if (cnt_r != 32'hFFFF_FFFF) begin
                cnt_r <= cnt_r + 32'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Frame shift register: loaded at qualification, shifted MSB-first per bit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shift_r   <= 40'd0;
            bit_idx_r <= 6'd0;
        end else if (latch_s) begin
            shift_r   <= {RH_INT, RH_DEC, T_INT, T_DEC,
                          calc_csum(RH_INT, RH_DEC, T_INT, T_DEC, CSUM_ERR)};
            bit_idx_r <= 6'd0;
        end else if (bit_done_s) begin
            shift_r   <= {shift_r[38:0], 1'b0};
            bit_idx_r <= bit_idx_r + 6'd1;
        end else begin
            shift_r   <= shift_r;
            bit_idx_r <= bit_idx_r;
        end
    end

    // Registered outputs decoded from the next state so they align with state_r.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            frames_r  <= 16'd0;
        end else begin
            data_oe_r <= (state_s == ST_ACK_LOW) || (state_s == ST_BIT_LOW) ||
                         (state_s == ST_END_LOW);
            busy_r    <= (state_s != ST_IDLE) && (state_s != ST_HOST_LOW);
            done_r    <= frame_done_s;
            frames_r  <= frame_done_s ? (frames_r + 16'd1) : frames_r;
        end
    end

    assign DATA_OE = data_oe_r;
    assign BUSY    = busy_r;
    assign DONE    = done_r;
    assign FRAMES  = frames_r;

endmodule

// File: tb/tb_dht11_responder.sv
module tb_dht11_responder;

    // 1 MHz clock gives one cycle per microsecond; start threshold scaled to 160 us.
    localparam int CLK_HZ   = 1000000;
    localparam int CYC      = 1;
    localparam int START_US = 160;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        host_low;
    logic        data_line;
    logic        DATA_OE;
    logic [7:0]  rh_int, rh_dec, t_int, t_dec;
    logic        csum_err;
    logic        BUSY, DONE;
    logic [15:0] FRAMES;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frames = 0;
    int runs[$];
    int done_seen;

    // Wired-AND open-drain line with pull-up.
    assign data_line = ~(host_low | DATA_OE);

    dht11_responder #(
        .CLK_FPGA(CLK_HZ),
        .START_MIN_US(START_US)
    ) dut (
        .CLK(CLK), .RESET(RESET), .DATA_IN(data_line), .DATA_OE(DATA_OE),
        .RH_INT(rh_int), .RH_DEC(rh_dec), .T_INT(t_int), .T_DEC(t_dec),
        .CSUM_ERR(csum_err), .BUSY(BUSY), .DONE(DONE), .FRAMES(FRAMES)
    );

    always #5 CLK = ~CLK;

    // Reference: the 40-bit frame a DHT11 sends for these bytes.
    function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d,
                                                input logic err);
        int s;
        logic [7:0] cs;
        s  = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        cs = 8'(s);
        if (err) cs = 8'(255 - s);
        return {a, b, c, d, cs};
    endfunction

    task automatic send_start(input int low_us);
        @(negedge CLK);
        host_low = 1'b1;
        repeat (low_us * CYC) @(negedge CLK);
        host_low = 1'b0;
    endtask

    // Records DATA_OE run lengths until DONE; disturbs inputs and host line mid-frame.
    task automatic capture(input int max_cycles);
        logic prev;
        int len;
        int after;
        runs.delete();
        done_seen = 0;
        prev  = 1'b0;
        len   = 0;
        after = 0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge CLK);
            if (c == 150) begin
                rh_int   = 8'($urandom);
                rh_dec   = 8'($urandom);
                t_int    = 8'($urandom);
                t_dec    = 8'($urandom);
                csum_err = 1'($urandom);
            end
            if (c == 300) host_low = 1'b1;
            if (c == 520) host_low = 1'b0;
            if (DONE) done_seen++;
            if (DATA_OE == prev) begin
                len++;
            end else begin
                runs.push_back(len);
                prev = DATA_OE;
                len  = 1;
            end
            if (done_seen > 0) after++;
            if (after >= 3) break;
        end
        host_low = 1'b0;
    endtask

    task automatic do_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input logic err,
                            input int low_us);
        logic [39:0] exp_bits;
        logic [39:0] got_bits;
        int exp_w;
        rh_int = a; rh_dec = b; t_int = c; t_dec = d; csum_err = err;
        exp_bits = model_frame(a, b, c, d, err);
        send_start(low_us);
        capture(6000);
        exp_frames++;
        n_cmp++;
        if (runs.size() !== 84) begin
            n_bad++;
            $display("FAIL %s run_count got=%0d want=84", name, runs.size());
        end else begin
            n_cmp++;
            if (runs[0] < 31 || runs[0] > 34) begin
                n_bad++;
                $display("FAIL %s turn got=%0d want=31..34", name, runs[0]);
            end
            n_cmp++;
            if (runs[1] !== 80 * CYC) begin
                n_bad++;
                $display("FAIL %s ack_low got=%0d want=%0d", name, runs[1], 80 * CYC);
            end
            n_cmp++;
            if (runs[2] !== 80 * CYC) begin
                n_bad++;
                $display("FAIL %s ack_high got=%0d want=%0d", name, runs[2], 80 * CYC);
            end
            for (int i = 0; i < 40; i++) begin
                exp_w = exp_bits[39 - i] ? 70 * CYC : 26 * CYC;
                got_bits[39 - i] = (runs[4 + 2 * i] > 48 * CYC);
                n_cmp++;
                if (runs[3 + 2 * i] !== 50 * CYC) begin
                    n_bad++;
                    $display("FAIL %s bit%0d_low got=%0d want=%0d", name, i, runs[3 + 2 * i], 50 * CYC);
                end
                n_cmp++;
                if (runs[4 + 2 * i] !== exp_w) begin
                    n_bad++;
                    $display("FAIL %s bit%0d_high got=%0d want=%0d", name, i, runs[4 + 2 * i], exp_w);
                end
            end
            n_cmp++;
            if (got_bits !== exp_bits) begin
                n_bad++;
                $display("FAIL %s frame got=%010h want=%010h", name, got_bits, exp_bits);
            end
            n_cmp++;
            if (runs[83] !== 50 * CYC) begin
                n_bad++;
                $display("FAIL %s end_low got=%0d want=%0d", name, runs[83], 50 * CYC);
            end
        end
        n_cmp++;
        if (done_seen !== 1) begin
            n_bad++;
            $display("FAIL %s done_pulses got=%0d want=1", name, done_seen);
        end
        n_cmp++;
        if (FRAMES !== 16'(exp_frames)) begin
            n_bad++;
            $display("FAIL %s frames got=%0d want=%0d", name, FRAMES, exp_frames);
        end
        n_cmp++;
        if (BUSY !== 1'b0 || DATA_OE !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_after got=busy%0b/oe%0b want=0/0", name, BUSY, DATA_OE);
        end
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1; host_low = 1'b0;
        rh_int = 8'h00; rh_dec = 8'h00; t_int = 8'h00; t_dec = 8'h00; csum_err = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (DATA_OE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || FRAMES !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state got=oe%0b busy%0b done%0b frames%0d want=0/0/0/0",
                     DATA_OE, BUSY, DONE, FRAMES);
        end
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_midframe_reset();
        int rises;
        logic prev;
        rh_int = 8'h37; rh_dec = 8'h00; t_int = 8'h19; t_dec = 8'h00; csum_err = 1'b0;
        send_start(180);
        rises = 0;
        prev  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (DATA_OE && !prev) rises++;
            prev = DATA_OE;
            if (rises == 13) break;
        end
        n_cmp++;
        if (rises !== 13 || DATA_OE !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_reach_bit12 got=rises%0d oe%0b want=13/1", rises, DATA_OE);
        end
        RESET = 1'b1;
        #1;
        n_cmp++;
        if (DATA_OE !== 1'b0 || BUSY !== 1'b0 || FRAMES !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_reset got=oe%0b busy%0b frames%0d want=0/0/0", DATA_OE, BUSY, FRAMES);
        end
        @(negedge CLK);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        exp_frames = 0;
        do_frame("after_reset", 8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 180);
    endtask

    task automatic test_short_pulse();
        int oe_hits;
        int busy_hits;
        int done_hits;
        for (int k = 0; k < 3; k++) begin
            oe_hits = 0; busy_hits = 0; done_hits = 0;
            send_start(int'($urandom_range(20, 140)));
            for (int c = 0; c < 400; c++) begin
                @(negedge CLK);
                if (DATA_OE) oe_hits++;
                if (BUSY) busy_hits++;
                if (DONE) done_hits++;
            end
            n_cmp++;
            if (oe_hits !== 0 || busy_hits !== 0 || done_hits !== 0) begin
                n_bad++;
                $display("FAIL short_pulse%0d got=oe%0d busy%0d done%0d want=0/0/0",
                         k, oe_hits, busy_hits, done_hits);
            end
            n_cmp++;
            if (FRAMES !== 16'(exp_frames)) begin
                n_bad++;
                $display("FAIL short_pulse%0d_frames got=%0d want=%0d", k, FRAMES, exp_frames);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            do_frame($sformatf("random%0d", k), 8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 1'($urandom), int'($urandom_range(170, 400)));
        end
    endtask

    initial begin
        test_reset();
        test_midframe_reset();
        do_frame("basic", 8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 180);
        test_short_pulse();
        do_frame("csum_err", 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 200);
        do_frame("all_ones", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 180);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
